// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle driven by vga_sync_gen and consumed by the drawing blocks.
// The master modport drives these signals; the slave modport only reads them.
interface vga_sync_gen_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        move_clock;

  modport master (output hcount, vcount, blank, hsync, vsync, frame_start, move_clock);
  modport slave  (input  hcount, vcount, blank, hsync, vsync, frame_start, move_clock);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel/line counters, blank, h/v sync, a frame-start strobe
// and the free-running move_clock square wave used by the sprite/player logic.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned MOVE_HALF   = 100000
) (
  input  logic           pixel_clock,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MoveW   = (MOVE_HALF > 1) ? $clog2(MOVE_HALF) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_HALF - 1);
  localparam logic [10:0]      HLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0]      VLast    = 11'(V_TOTAL - 1);

  // 12-bit thresholds so a region ending exactly at 2048 still compares correctly.
  localparam logic [11:0] HActEnd  = 12'(H_ACTIVE);
  localparam logic [11:0] HSyncBeg = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VActEnd  = 12'(V_ACTIVE);
  localparam logic [11:0] VSyncBeg = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VSyncEnd = 12'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || H_TOTAL == 0) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must be in 1..2048");
  end
  if (V_TOTAL > 2048 || V_TOTAL == 0) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must be in 1..2048");
  end

  logic [DivW-1:0]  div_q, div_d;
  logic [MoveW-1:0] move_cnt_q, move_cnt_d;
  logic [10:0]      hcount_q, hcount_d;
  logic [10:0]      vcount_q, vcount_d;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic             move_clock_q, move_clock_d;
  logic             pix_en, h_wrap, v_wrap;

  always_comb begin
    pix_en = (div_q == DivLast);
    div_d  = pix_en ? '0 : div_q + DivW'(1);
    h_wrap = (hcount_q == HLast);
    v_wrap = (vcount_q == VLast);
  end

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // Flags are decoded from the next counter values so they register in step with them.
  always_comb begin
    blank_d       = ({1'b0, hcount_d} >= HActEnd) || ({1'b0, vcount_d} >= VActEnd);
    hsync_d       = (({1'b0, hcount_d} >= HSyncBeg) && ({1'b0, hcount_d} < HSyncEnd)) ?
                    SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = (({1'b0, vcount_d} >= VSyncBeg) && ({1'b0, vcount_d} < VSyncEnd)) ?
                    SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start_d = pix_en && h_wrap && v_wrap;
  end

  always_comb begin
    if (move_cnt_q == MoveLast) begin
      move_cnt_d   = '0;
      move_clock_d = ~move_clock_q;
    end else begin
      move_cnt_d   = move_cnt_q + MoveW'(1);
      move_clock_d = move_clock_q;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      div_q         <= '0;
      move_cnt_q    <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
      move_clock_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      move_cnt_q    <= move_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      move_clock_q  <= move_clock_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.blank       = blank_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
  assign vga.move_clock  = move_clock_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-geometry, small-geometry and divided-clock instances
// checked each cycle against a closed-form raster model, plus a checkpoint table.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        move_clock;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
  } sb_t;

  typedef struct {
    bit   rst_n;
    int   cycles;
    obs_t exp;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();
  vga_sync_gen_if vga_c ();

  vga_sync_gen #(
    .MOVE_HALF (4)
  ) u_dut_a (
    .pixel_clock (clk),
    .reset_n     (reset_n),
    .vga         (vga_a)
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .MOVE_HALF (3)
  ) u_dut_b (
    .pixel_clock (clk),
    .reset_n     (reset_n),
    .vga         (vga_b)
  );

  vga_sync_gen #(
    .CLK_DIV  (2),
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .MOVE_HALF (4)
  ) u_dut_c (
    .pixel_clock (clk),
    .reset_n     (reset_n),
    .vga         (vga_c)
  );

  // Expected outputs after n enabled clock edges since reset was last released.
  function automatic obs_t model(int n, int d, int ha, int hfp, int hs, int hbp,
                                 int va, int vfp, int vs, int vbp, int mh);
    obs_t o;
    int ht, vt, p, h, v;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p  = (n / d) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    o.hcount      = 11'(h);
    o.vcount      = 11'(v);
    o.blank       = (h >= ha) || (v >= va);
    o.hsync       = !((h >= ha + hfp) && (h < ha + hfp + hs));
    o.vsync       = !((v >= va + vfp) && (v < va + vfp + vs));
    o.frame_start = (n > 0) && (n % d == 0) && ((n / d) % (ht * vt) == 0);
    o.move_clock  = ((n / mh) % 2) == 1;
    return o;
  endfunction

  function automatic sb_t expect_all(int n);
    sb_t s;
    s.a = model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    s.b = model(n, 1, 8, 1, 2, 1, 4, 1, 1, 1, 3);
    s.c = model(n, 2, 8, 1, 2, 1, 4, 1, 1, 1, 4);
    return s;
  endfunction

  function automatic obs_t mk(int h, int v, bit b, bit hs, bit vs, bit fs, bit mv);
    obs_t o;
    o.hcount      = 11'(h);
    o.vcount      = 11'(v);
    o.blank       = b;
    o.hsync       = hs;
    o.vsync       = vs;
    o.frame_start = fs;
    o.move_clock  = mv;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("h=%0d v=%0d blank=%0b hs=%0b vs=%0b fs=%0b mv=%0b", o.hcount, o.vcount,
                     o.blank, o.hsync, o.vsync, o.frame_start, o.move_clock);
  endfunction

  function automatic obs_t obs_a();
    return {vga_a.hcount, vga_a.vcount, vga_a.blank, vga_a.hsync, vga_a.vsync,
            vga_a.frame_start, vga_a.move_clock};
  endfunction

  function automatic obs_t obs_b();
    return {vga_b.hcount, vga_b.vcount, vga_b.blank, vga_b.hsync, vga_b.vsync,
            vga_b.frame_start, vga_b.move_clock};
  endfunction

  function automatic obs_t obs_c();
    return {vga_c.hcount, vga_c.vcount, vga_c.blank, vga_c.hsync, vga_c.vsync,
            vga_c.frame_start, vga_c.move_clock};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all(input sb_t e);
    check("sb_a", obs_a(), e.a);
    check("sb_b", obs_b(), e.b);
    check("sb_c", obs_c(), e.c);
  endtask

  // Scoreboard: expectation queued at each driven edge, compared on the falling edge.
  sb_t sb_q[$];
  int  n_model     = 0;
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      n_model     <= 0;
      model_valid <= 1'b1;
      sb_q.push_back(expect_all(0));
    end else if (model_valid) begin
      n_model <= n_model + 1;
      sb_q.push_back(expect_all(n_model + 1));
    end
  end

  always @(negedge clk) begin
    while (sb_q.size() > 0) compare_all(sb_q.pop_front());
  end

  initial begin
    vec_t tbl[13];
    int   cnt, per, vs_n, hs_n, hmax, vmax, tog;
    logic prev;

    // Checkpoints on the default-geometry instance (MOVE_HALF=4).
    tbl[0]  = '{rst_n: 1'b0, cycles: 3,   exp: mk(0,   0, 0, 1, 1, 0, 0)};
    tbl[1]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(1,   0, 0, 1, 1, 0, 0)};
    tbl[2]  = '{rst_n: 1'b1, cycles: 638, exp: mk(639, 0, 0, 1, 1, 0, 1)};
    tbl[3]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(640, 0, 1, 1, 1, 0, 0)};
    tbl[4]  = '{rst_n: 1'b1, cycles: 16,  exp: mk(656, 0, 1, 0, 1, 0, 0)};
    tbl[5]  = '{rst_n: 1'b1, cycles: 95,  exp: mk(751, 0, 1, 0, 1, 0, 1)};
    tbl[6]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(752, 0, 1, 1, 1, 0, 0)};
    tbl[7]  = '{rst_n: 1'b1, cycles: 47,  exp: mk(799, 0, 1, 1, 1, 0, 1)};
    tbl[8]  = '{rst_n: 1'b1, cycles: 1,   exp: mk(0,   1, 0, 1, 1, 0, 0)};
    tbl[9]  = '{rst_n: 1'b1, cycles: 300, exp: mk(300, 1, 0, 1, 1, 0, 1)};
    tbl[10] = '{rst_n: 1'b0, cycles: 1,   exp: mk(0,   0, 0, 1, 1, 0, 0)};
    tbl[11] = '{rst_n: 1'b0, cycles: 4,   exp: mk(0,   0, 0, 1, 1, 0, 0)};
    tbl[12] = '{rst_n: 1'b1, cycles: 1,   exp: mk(1,   0, 0, 1, 1, 0, 0)};

    reset_n = 1'b0;
    foreach (tbl[i]) begin
      reset_n = tbl[i].rst_n;
      repeat (tbl[i].cycles) @(negedge clk);
      check($sformatf("tbl%0d", i), obs_a(), tbl[i].exp);
    end

    // Small geometry: one full frame between consecutive frame_start pulses.
    cnt = 0;
    while (vga_b.frame_start !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check_int("b_first_pulse_seen", int'(vga_b.frame_start === 1'b1), 1);
    check_int("b_pulse_at_origin", int'(vga_b.hcount) + int'(vga_b.vcount), 0);
    per = 0; vs_n = 0; hs_n = 0; hmax = 0; vmax = 0;
    do begin
      @(negedge clk);
      per++;
      if (vga_b.vsync === 1'b0) vs_n++;
      if (vga_b.hsync === 1'b0) hs_n++;
      if (int'(vga_b.hcount) > hmax) hmax = int'(vga_b.hcount);
      if (int'(vga_b.vcount) > vmax) vmax = int'(vga_b.vcount);
    end while (vga_b.frame_start !== 1'b1 && per < 300);
    check_int("b_frame_period", per, 84);
    check_int("b_vsync_cycles", vs_n, 12);
    check_int("b_hsync_cycles", hs_n, 14);
    check_int("b_hcount_max", hmax, 11);
    check_int("b_vcount_max", vmax, 6);

    // Divided clock: frame period doubles.
    cnt = 0;
    while (vga_c.frame_start !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check_int("c_first_pulse_seen", int'(vga_c.frame_start === 1'b1), 1);
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (vga_c.frame_start !== 1'b1 && per < 400);
    check_int("c_frame_period", per, 168);

    // Restart: divided instance first advances on the second edge after release.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_int("c_reset_move", int'(vga_c.move_clock), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_int("c_hold_first_edge", int'(vga_c.hcount), 0);
    check_int("a_first_edge", int'(vga_a.hcount), 1);
    @(negedge clk);
    check_int("c_advance_second_edge", int'(vga_c.hcount), 1);

    // move_clock keeps its own pace regardless of the pixel divider.
    tog = 0;
    prev = vga_c.move_clock;
    repeat (32) begin
      @(negedge clk);
      if (vga_c.move_clock !== prev) tog++;
      prev = vga_c.move_clock;
    end
    check_int("c_move_toggles", tog, 8);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing: pixel counters, blanking, and horizontal/vertical sync.
- Also generates the slow movement clock used by sprite/player blocks.
- Sits upstream of every drawing block, which consumes hcount, vcount, blank and move_clock.
- hsync and vsync drive the VGA connector directly.

Parameters:
- CLK_DIV, 1, pixel_clock cycles per pixel advance (1 = clock is the pixel clock; 2 = 50 MHz board clock).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low).
- MOVE_HALF, 100000, pixel_clock cycles per half-period of move_clock.

Ports:
- pixel_clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- hcount  output  11  current pixel column, 0..H_TOTAL-1.
- vcount  output  11  current line, 0..V_TOTAL-1.
- blank  output  1  high outside the active area.
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE.
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE.
- frame_start  output  1  one pixel_clock pulse when the raster enters (0,0).
- move_clock  output  1  square wave for the movement logic.

Behaviour:
- Reset is synchronous, active-low. reset_n is sampled on the pixel_clock edge. All outputs are registered.
- Reset values: hcount=0, vcount=0, blank=0, hsync=vsync=!SYNC_ACTIVE, frame_start=0, move_clock=0, divider=0, move counter=0.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Pixel enable: an internal counter runs 0..CLK_DIV-1. Enable is high on the cycle it equals CLK_DIV-1, then the counter wraps to 0.
  - CLK_DIV=1: enable is high every cycle.
  - The first advance occurs CLK_DIV cycles after reset_n rises.
- On each enable:
  - If hcount == H_TOTAL-1: hcount <= 0.
    - If vcount == V_TOTAL-1 as well: vcount <= 0; otherwise vcount <= vcount+1.
  - Otherwise: hcount <= hcount+1.
- Without enable, hcount and vcount hold.
- Flags are registered together with the counters and describe the *next* counter values, so all outputs stay cycle-aligned (no skew between count and flags):
  - blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
  - hsync = SYNC_ACTIVE while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise inverted.
  - vsync = SYNC_ACTIVE while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise inverted. vsync spans whole lines, including their blanking.
- frame_start:
  - High for exactly one pixel_clock cycle: the cycle in which the counters have just wrapped from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Never asserted out of reset; the first pulse comes after one full frame.
- move_clock:
  - A free-running counter on pixel_clock, independent of the pixel enable.
  - When the counter reaches MOVE_HALF-1: it clears and move_clock toggles. Period = 2*MOVE_HALF cycles, 50% duty.
  - Counter width = clog2(MOVE_HALF).
- Counter widths: 11-bit counters. Elaboration fails (generate-time error) if H_TOTAL or V_TOTAL exceeds 2048.
- Reset mid-frame: on the next edge with reset_n low, every output returns to its reset value, including a mid-pulse move_clock and hsync/vsync. The raster restarts at (0,0) with no partial frame_start.

Test Plan:
- Reset: hold reset_n low 5 cycles at (hcount,vcount)=(300,200), CLK_DIV=1 -> hcount=0, vcount=0, blank=0, hsync=vsync=1, move_clock=0 on the first edge with reset low; release -> hcount=1 one cycle later.
- Line timing, defaults -> blank rises at hcount=640; hsync low exactly for hcount 656..751 (96 cycles); hcount 799 is followed by 0 and vcount increments by 1.
- Frame timing, defaults -> blank high for vcount 480..524; vsync low for 2 lines (1600 cycles) at vcount 490..491; frame_start pulses once every 420000 cycles, in the cycle showing (0,0).
- CLK_DIV=2 -> hcount advances every second cycle, first at cycle 2 after reset; each value held 2 cycles; frame period 840000 cycles.
- move_clock, MOVE_HALF=4 -> toggles every 4 cycles (period 8); unaffected by CLK_DIV; reset asserted while high forces 0 on the next edge.
- Small geometry (H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1; V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1) -> hcount wraps 11->0, vcount wraps 6->0, hsync active at hcount 9..10, vsync active at vcount 5.
